key_debounce: RTL



---
 rtl/key_debounce.sv | 83 ++++++++
 1 files changed

// File: rtl/key_debounce.sv
// Purpose : per-key 2-flop synchronizer + stability counter; emits a clean level and one-cycle press/release pulses.
// Latency : D+2 rising edges from the first sampling of a new stable key_in level to key_level/pulse update (D = DEBOUNCE_CYCLES).
// Backpressure: none; free-running, outputs are levels/pulses with no handshake.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   key_in       raw asynchronous button levels, 1 = pressed
//   key_level    registered debounced level per key
//   key_press    one-cycle pulse on each accepted 0->1 transition
//   key_release  one-cycle pulse on each accepted 1->0 transition
module key_debounce #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] level_q,   level_d;
  logic [N_KEYS-1:0] press_q,   press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [CNT_W-1:0]  cnt_q [N_KEYS];
  logic [CNT_W-1:0]  cnt_d [N_KEYS];

  // Per channel: STABLE when sync2 matches the accepted level (counter held at 0),
  // PENDING while it differs. A single matching sample drops back to STABLE and
  // discards the count; D consecutive differing samples flip the level.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i]   = sync2_q[i];
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= key_in;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule
